// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit.
//   XLEN        : datapath / PC width
//   CNT_W       : perf counter width
//   INSTR_BYTES : instruction size; also the target alignment requirement
package branch_resolve_unit_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned CNT_W       = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned ALIGN_W     = $clog2(INSTR_BYTES);

    typedef enum logic {BRU_IDLE, BRU_REDIRECT} bru_state_t;

    // Predictor update payload
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] target;
    } bp_update_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Execute/fetch-facing bundle of the branch resolve unit.
//   ex_*/pc/imm/rs1/is_*/branch_taken/pred_*/trap_flush : instr from execute
//   redirect_*                                           : redirect handshake to fetch
//   flush/misalign*/upd_*/ *_cnt                          : pulses, predictor update, counters
// master = environment driving instructions, slave = the unit.
interface branch_resolve_unit_if;
    import branch_resolve_unit_pkg::*;

    logic            ex_valid_i;
    logic            ex_ready_o;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] rs1_i;
    logic            is_b_type_i;
    logic            is_jal_i;
    logic            is_jalr_i;
    logic            branch_taken_i;
    logic            pred_taken_i;
    logic [XLEN-1:0] pred_target_i;
    logic            trap_flush_i;
    logic            redirect_valid_o;
    logic            redirect_ready_i;
    logic [XLEN-1:0] redirect_pc_o;
    logic            flush_o;
    logic            misalign_o;
    logic [XLEN-1:0] misalign_addr_o;
    logic            upd_valid_o;
    logic [XLEN-1:0] upd_pc_o;
    logic            upd_taken_o;
    logic [XLEN-1:0] upd_target_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    modport master (
        output ex_valid_i, pc_i, imm_i, rs1_i, is_b_type_i, is_jal_i, is_jalr_i,
               branch_taken_i, pred_taken_i, pred_target_i, trap_flush_i, redirect_ready_i,
        input  ex_ready_o, redirect_valid_o, redirect_pc_o, flush_o, misalign_o,
               misalign_addr_o, upd_valid_o, upd_pc_o, upd_taken_o, upd_target_o,
               branch_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  ex_valid_i, pc_i, imm_i, rs1_i, is_b_type_i, is_jal_i, is_jalr_i,
               branch_taken_i, pred_taken_i, pred_target_i, trap_flush_i, redirect_ready_i,
        output ex_ready_o, redirect_valid_o, redirect_pc_o, flush_o, misalign_o,
               misalign_addr_o, upd_valid_o, upd_pc_o, upd_taken_o, upd_target_o,
               branch_cnt_o, mispred_cnt_o
    );

endinterface

// File: rtl/branch_resolve_unit_target_calc.sv
// bru_target_calc: combinational resolution of one control-flow instr.
//   in : pc, imm, rs1, instr class flags, comparator result, fetch prediction
//   out: ctrl_c, taken_c, target_c (taken target), actual_c (real next PC),
//        mispred_c (actual != predicted next PC), misalign_c (taken target unaligned)
module bru_target_calc
    import branch_resolve_unit_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            is_b_type,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic            branch_taken,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    output logic            ctrl_c,
    output logic            taken_c,
    output logic [XLEN-1:0] target_c,
    output logic [XLEN-1:0] actual_c,
    output logic            mispred_c,
    output logic            misalign_c
);
    logic [XLEN-1:0] seq_c;
    logic [XLEN-1:0] predicted_c;

    assign ctrl_c  = is_b_type | is_jal | is_jalr;
    assign taken_c = branch_taken | is_jal | is_jalr;
    assign seq_c   = pc + XLEN'(INSTR_BYTES);

    // JALR clears bit 0 of the computed address; all sums wrap at XLEN
    assign target_c = is_jalr ? ((rs1 + imm) & ~XLEN'(1)) : (pc + imm);

    assign actual_c    = taken_c ? target_c : seq_c;
    assign predicted_c = pred_taken ? pred_target : seq_c;

    // Non-control instrs that fetch predicted taken also mispredict here
    assign mispred_c  = (actual_c != predicted_c);
    assign misalign_c = taken_c & (target_c[ALIGN_W-1:0] != '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves B-type/JAL/JALR in execute, redirects fetch on mispredict.
//   clk, reset : clock and synchronous active-high reset
//   bru        : slave side of branch_resolve_unit_if (execute input, redirect handshake,
//                flush/misalign pulses, predictor update, perf counters)
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_unit_if.slave  bru
);
    localparam logic [0:0] ST_IDLE     = 1'(BRU_IDLE);
    localparam logic [0:0] ST_REDIRECT = 1'(BRU_REDIRECT);

    logic [0:0]       state_q, state_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             flush_q, flush_d;
    logic             misalign_q, misalign_d;
    logic [XLEN-1:0]  misalign_addr_q, misalign_addr_d;
    logic             upd_valid_q, upd_valid_d;
    bp_update_t       upd_q, upd_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic             ctrl_c, taken_c, mispred_c, misalign_c, accept_c;
    logic [XLEN-1:0]  target_c, actual_c;

    bru_target_calc u_target_calc (
        .pc           (bru.pc_i),
        .imm          (bru.imm_i),
        .rs1          (bru.rs1_i),
        .is_b_type    (bru.is_b_type_i),
        .is_jal       (bru.is_jal_i),
        .is_jalr      (bru.is_jalr_i),
        .branch_taken (bru.branch_taken_i),
        .pred_taken   (bru.pred_taken_i),
        .pred_target  (bru.pred_target_i),
        .ctrl_c       (ctrl_c),
        .taken_c      (taken_c),
        .target_c     (target_c),
        .actual_c     (actual_c),
        .mispred_c    (mispred_c),
        .misalign_c   (misalign_c)
    );

    // A trap flush in the same cycle kills the incoming instr entirely
    assign accept_c = bru.ex_valid_i & (state_q == ST_IDLE) & ~bru.trap_flush_i;

    // Next-state, pulse and counter logic
    always_comb begin
        state_d         = state_q;
        redirect_pc_d   = redirect_pc_q;
        flush_d         = 1'b0;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
        upd_valid_d     = 1'b0;
        upd_d           = upd_q;
        branch_cnt_d    = branch_cnt_q;
        mispred_cnt_d   = mispred_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c && mispred_c && !misalign_c) begin
                    state_d       = ST_REDIRECT;
                    redirect_pc_d = actual_c;
                    flush_d       = 1'b1;
                    mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
                end
            end
            ST_REDIRECT: begin
                if (bru.redirect_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept_c && misalign_c) begin
            misalign_d      = 1'b1;
            misalign_addr_d = target_c;
        end

        if (accept_c && ctrl_c) begin
            upd_valid_d  = 1'b1;
            upd_d.pc     = bru.pc_i;
            upd_d.taken  = taken_c;
            upd_d.target = target_c;
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end

        // Trap flush drops any pending or just-started redirect
        if (bru.trap_flush_i) begin
            state_d = ST_IDLE;
            flush_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            redirect_pc_q   <= '0;
            flush_q         <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
            upd_valid_q     <= 1'b0;
            upd_q           <= '0;
            branch_cnt_q    <= '0;
            mispred_cnt_q   <= '0;
        end else begin
            state_q         <= state_d;
            redirect_pc_q   <= redirect_pc_d;
            flush_q         <= flush_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
            upd_valid_q     <= upd_valid_d;
            upd_q           <= upd_d;
            branch_cnt_q    <= branch_cnt_d;
            mispred_cnt_q   <= mispred_cnt_d;
        end
    end

    assign bru.ex_ready_o       = (state_q == ST_IDLE);
    assign bru.redirect_valid_o = (state_q == ST_REDIRECT);
    assign bru.redirect_pc_o    = redirect_pc_q;
    assign bru.flush_o          = flush_q;
    assign bru.misalign_o       = misalign_q;
    assign bru.misalign_addr_o  = misalign_addr_q;
    assign bru.upd_valid_o      = upd_valid_q;
    assign bru.upd_pc_o         = upd_q.pc;
    assign bru.upd_taken_o      = upd_q.taken;
    assign bru.upd_target_o     = upd_q.target;
    assign bru.branch_cnt_o     = branch_cnt_q;
    assign bru.mispred_cnt_o    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: stimulus pushes expected redirects,
// flushes, misaligns and predictor updates; a negedge monitor pops and compares.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    logic [63:0] exp_redir[$];
    logic [63:0] exp_flush[$];
    logic [63:0] exp_mis[$];
    bp_update_t  exp_upd[$];

    branch_resolve_unit_if bus();

    branch_resolve_unit dut (
        .clk   (clk),
        .reset (reset),
        .bru   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one instr for a single cycle; returns #1 after the accepting edge
    task automatic issue(input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] rs1,
                         input logic b, input logic jal, input logic jalr, input logic bt,
                         input logic pt, input logic [63:0] ptgt, input logic trap);
        bus.ex_valid_i     = 1'b1;
        bus.pc_i           = pc;
        bus.imm_i          = imm;
        bus.rs1_i          = rs1;
        bus.is_b_type_i    = b;
        bus.is_jal_i       = jal;
        bus.is_jalr_i      = jalr;
        bus.branch_taken_i = bt;
        bus.pred_taken_i   = pt;
        bus.pred_target_i  = ptgt;
        bus.trap_flush_i   = trap;
        @(posedge clk); #1;
        bus.ex_valid_i     = 1'b0;
        bus.is_b_type_i    = 1'b0;
        bus.is_jal_i       = 1'b0;
        bus.is_jalr_i      = 1'b0;
        bus.branch_taken_i = 1'b0;
        bus.pred_taken_i   = 1'b0;
        bus.trap_flush_i   = 1'b0;
    endtask

    function automatic bp_update_t mk_upd(input logic [63:0] pc, input logic tk,
                                          input logic [63:0] tgt);
        bp_update_t u;
        u.pc     = pc;
        u.taken  = tk;
        u.target = tgt;
        return u;
    endfunction

    // Monitor: compare every DUT-presented event against the queues
    always @(negedge clk) begin
        if (bus.upd_valid_o) begin
            if (exp_upd.size() == 0) begin
                check("unexpected_upd", 64'(bus.upd_pc_o), 64'hDEAD);
            end else begin
                bp_update_t e;
                e = exp_upd.pop_front();
                check("upd_pc", 64'(bus.upd_pc_o), 64'(e.pc));
                check("upd_taken", 64'(bus.upd_taken_o), 64'(e.taken));
                check("upd_target", 64'(bus.upd_target_o), 64'(e.target));
            end
        end
        if (bus.flush_o) begin
            if (exp_flush.size() == 0) check("unexpected_flush", 64'(bus.redirect_pc_o), 64'hDEAD);
            else check("flush_pc", 64'(bus.redirect_pc_o), exp_flush.pop_front());
        end
        if (bus.misalign_o) begin
            if (exp_mis.size() == 0) check("unexpected_misalign", 64'(bus.misalign_addr_o), 64'hDEAD);
            else check("misalign_addr", 64'(bus.misalign_addr_o), exp_mis.pop_front());
        end
        if (bus.redirect_valid_o && bus.redirect_ready_i) begin
            if (exp_redir.size() == 0) check("unexpected_redirect", 64'(bus.redirect_pc_o), 64'hDEAD);
            else check("redirect_pc", 64'(bus.redirect_pc_o), exp_redir.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.ex_valid_i = 1'b0;       bus.pc_i = '0;          bus.imm_i = '0;
        bus.rs1_i = '0;              bus.is_b_type_i = 1'b0; bus.is_jal_i = 1'b0;
        bus.is_jalr_i = 1'b0;        bus.branch_taken_i = 1'b0;
        bus.pred_taken_i = 1'b0;     bus.pred_target_i = '0; bus.trap_flush_i = 1'b0;
        bus.redirect_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_ready", 64'(bus.ex_ready_o), 64'd1);
        check("rst_rvalid", 64'(bus.redirect_valid_o), 64'd0);
        check("rst_rpc", 64'(bus.redirect_pc_o), 64'd0);
        check("rst_bcnt", 64'(bus.branch_cnt_o), 64'd0);
        check("rst_mcnt", 64'(bus.mispred_cnt_o), 64'd0);

        // 1: BEQ taken, predicted not taken -> redirect 0x1020
        exp_redir.push_back(64'h1020);
        exp_flush.push_back(64'h1020);
        exp_upd.push_back(mk_upd(64'h1000, 1'b1, 64'h1020));
        issue(64'h1000, 64'h20, 64'h0, 1, 0, 0, 1, 0, 64'h0, 0);
        check("t1_rvalid", 64'(bus.redirect_valid_o), 64'd1);
        check("t1_flush", 64'(bus.flush_o), 64'd1);
        check("t1_ready", 64'(bus.ex_ready_o), 64'd0);
        check("t1_mcnt", 64'(bus.mispred_cnt_o), 64'd1);
        @(posedge clk); #1;
        check("t1_rvalid_done", 64'(bus.redirect_valid_o), 64'd0);
        check("t1_flush_done", 64'(bus.flush_o), 64'd0);
        check("t1_ready_back", 64'(bus.ex_ready_o), 64'd1);

        // 2: BNE not taken, predicted not taken
        exp_upd.push_back(mk_upd(64'h1100, 1'b0, 64'h1140));
        issue(64'h1100, 64'h40, 64'h0, 1, 0, 0, 0, 0, 64'h0, 0);
        check("t2_rvalid", 64'(bus.redirect_valid_o), 64'd0);
        check("t2_ready", 64'(bus.ex_ready_o), 64'd1);
        check("t2_bcnt", 64'(bus.branch_cnt_o), 64'd2);

        // 3: JALR 0x2003+4 -> 0x2006, prediction right; target not word aligned
        exp_upd.push_back(mk_upd(64'h1200, 1'b1, 64'h2006));
        exp_mis.push_back(64'h2006);
        issue(64'h1200, 64'h4, 64'h2003, 0, 0, 1, 0, 1, 64'h2006, 0);
        check("t3_rvalid", 64'(bus.redirect_valid_o), 64'd0);
        check("t3_bcnt", 64'(bus.branch_cnt_o), 64'd3);
        check("t3_mcnt", 64'(bus.mispred_cnt_o), 64'd1);

        // 4: predicted taken but not taken -> 0x3004, fetch stalls 3 cycles
        bus.redirect_ready_i = 1'b0;
        exp_flush.push_back(64'h3004);
        exp_upd.push_back(mk_upd(64'h3000, 1'b0, 64'h3100));
        issue(64'h3000, 64'h100, 64'h0, 1, 0, 0, 0, 1, 64'h3100, 0);
        check("t4_rvalid", 64'(bus.redirect_valid_o), 64'd1);
        check("t4_rpc", 64'(bus.redirect_pc_o), 64'h3004);
        check("t4_flush", 64'(bus.flush_o), 64'd1);
        // instr offered while busy must be ignored
        issue(64'h3800, 64'h8, 64'h0, 0, 1, 0, 0, 0, 64'h0, 0);
        for (int i = 0; i < 2; i++) begin
            check("t4_hold_valid", 64'(bus.redirect_valid_o), 64'd1);
            check("t4_hold_pc", 64'(bus.redirect_pc_o), 64'h3004);
            check("t4_hold_ready", 64'(bus.ex_ready_o), 64'd0);
            check("t4_hold_flush", 64'(bus.flush_o), 64'd0);
            @(posedge clk); #1;
        end
        exp_redir.push_back(64'h3004);
        bus.redirect_ready_i = 1'b1;
        @(posedge clk); #1;
        check("t4_rvalid_done", 64'(bus.redirect_valid_o), 64'd0);
        check("t4_bcnt", 64'(bus.branch_cnt_o), 64'd4);
        check("t4_mcnt", 64'(bus.mispred_cnt_o), 64'd2);

        // 5: trap during REDIRECT, then trap together with a mispredict
        bus.redirect_ready_i = 1'b0;
        exp_flush.push_back(64'h4008);
        exp_upd.push_back(mk_upd(64'h4000, 1'b1, 64'h4008));
        issue(64'h4000, 64'h8, 64'h0, 1, 0, 0, 1, 0, 64'h0, 0);
        check("t5_rvalid", 64'(bus.redirect_valid_o), 64'd1);
        bus.trap_flush_i = 1'b1;
        @(posedge clk); #1;
        bus.trap_flush_i = 1'b0;
        check("t5_trap_rvalid", 64'(bus.redirect_valid_o), 64'd0);
        check("t5_trap_ready", 64'(bus.ex_ready_o), 64'd1);
        issue(64'h4100, 64'h10, 64'h0, 1, 0, 0, 1, 0, 64'h0, 1);
        check("t5_same_rvalid", 64'(bus.redirect_valid_o), 64'd0);
        check("t5_same_flush", 64'(bus.flush_o), 64'd0);
        check("t5_bcnt", 64'(bus.branch_cnt_o), 64'd5);
        check("t5_mcnt", 64'(bus.mispred_cnt_o), 64'd3);
        bus.redirect_ready_i = 1'b1;

        // 6: JAL to unaligned 0x1006 -> misalign only
        exp_mis.push_back(64'h1006);
        exp_upd.push_back(mk_upd(64'h1000, 1'b1, 64'h1006));
        issue(64'h1000, 64'h6, 64'h0, 0, 1, 0, 0, 0, 64'h0, 0);
        check("t6_rvalid", 64'(bus.redirect_valid_o), 64'd0);
        check("t6_flush", 64'(bus.flush_o), 64'd0);
        check("t6_mcnt", 64'(bus.mispred_cnt_o), 64'd3);

        // Non-control instr predicted taken -> redirect to pc+4, no update
        exp_redir.push_back(64'h5004);
        exp_flush.push_back(64'h5004);
        issue(64'h5000, 64'h0, 64'h0, 0, 0, 0, 0, 1, 64'h6000, 0);
        check("nc_rvalid", 64'(bus.redirect_valid_o), 64'd1);
        @(posedge clk); #1;
        check("nc_bcnt", 64'(bus.branch_cnt_o), 64'd6);
        check("nc_mcnt", 64'(bus.mispred_cnt_o), 64'd4);

        // Reset while REDIRECT is pending
        bus.redirect_ready_i = 1'b0;
        exp_flush.push_back(64'h7010);
        exp_upd.push_back(mk_upd(64'h7000, 1'b1, 64'h7010));
        issue(64'h7000, 64'h10, 64'h0, 0, 1, 0, 0, 0, 64'h0, 0);
        check("rr_rvalid", 64'(bus.redirect_valid_o), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.redirect_ready_i = 1'b1;
        check("rr_rvalid0", 64'(bus.redirect_valid_o), 64'd0);
        check("rr_flush0", 64'(bus.flush_o), 64'd0);
        check("rr_upd0", 64'(bus.upd_valid_o), 64'd0);
        check("rr_rpc0", 64'(bus.redirect_pc_o), 64'd0);
        check("rr_updpc0", 64'(bus.upd_pc_o), 64'd0);
        check("rr_updtgt0", 64'(bus.upd_target_o), 64'd0);
        check("rr_misaddr0", 64'(bus.misalign_addr_o), 64'd0);
        check("rr_bcnt0", 64'(bus.branch_cnt_o), 64'd0);
        check("rr_mcnt0", 64'(bus.mispred_cnt_o), 64'd0);
        check("rr_ready", 64'(bus.ex_ready_o), 64'd1);

        // PC wrap: JAL from top of address space, correctly predicted
        exp_upd.push_back(mk_upd(64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 64'h10));
        issue(64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h0, 0, 1, 0, 0, 1, 64'h10, 0);
        check("wrap_rvalid", 64'(bus.redirect_valid_o), 64'd0);
        check("wrap_bcnt", 64'(bus.branch_cnt_o), 64'd1);
        check("wrap_mcnt", 64'(bus.mispred_cnt_o), 64'd0);

        repeat (2) @(posedge clk);
        #1;
        check("left_redir", 64'(exp_redir.size()), 64'd0);
        check("left_flush", 64'(exp_flush.size()), 64'd0);
        check("left_mis", 64'(exp_mis.size()), 64'd0);
        check("left_upd", 64'(exp_upd.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
